uart_fifo_echo: RTL and testbench
=================================

Name: uart_fifo_echo

Overview:
Parametrised UART transceiver for the FPGA serial-assistant link. It receives frames on uart_rx and checks parity and stop bits. Good bytes are buffered in an RX FIFO, and the FIFO contents are echoed back on uart_tx. Compared with the fixed 8N1 direct-loopback UART, it adds configurable frame format, buffering, echo gating and error reporting.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate; bit period DIV = CLK_FREQ/BAUD (truncated), DIV >= 8
DATA_BITS, 8, data bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, RX FIFO depth, power of 2, >= 2

Ports:
Clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
uart_rx  input  1  serial in, idle high, asynchronous to Clock
uart_tx  output  1  serial out, idle high
echo_en  input  1  1 = drain FIFO to uart_tx
rx_data  output  DATA_BITS  last received data word
rx_valid  output  1  1-cycle pulse per completed RX frame
parity_err  output  1  1-cycle pulse with rx_valid, parity mismatch
frame_err  output  1  1-cycle pulse with rx_valid, any stop bit sampled 0
overflow  output  1  1-cycle pulse, good byte dropped because FIFO full
fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, effective immediately):
  - uart_tx = 1; rx_data = 0; rx_valid, parity_err, frame_err, overflow = 0.
  - fifo_count = 0; FIFO emptied; both FSMs return to IDLE.
  - Applies mid-frame too; a partial frame is discarded.
- RX synchroniser: uart_rx passes through 2 flops before any use. All RX timing below is relative to the synchronised signal.
- RX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - IDLE: a 1->0 transition enters START.
  - START: sample at DIV/2 clocks. If the sample is 1, treat it as a glitch and return to IDLE with no outputs.
  - DATA: sample every DIV clocks thereafter, LSB first.
  - STOP: sample STOP_BITS stop bits. After the final stop sample, return to IDLE immediately, so a next start edge is accepted without waiting.
- Parity: expected bit = XOR(data) for even, ~XOR(data) for odd.
- Frame completion, in the cycle after the final stop sample:
  - rx_valid = 1 and rx_data updates; rx_data holds until the next frame.
  - parity_err and frame_err are set per the checks above.
- FIFO push:
  - Push only if parity_err = 0 and frame_err = 0.
  - If the FIFO is full and there is no same-cycle pop, drop the byte and pulse overflow (same cycle as rx_valid).
  - A push and pop in the same cycle are both accepted, including at full; fifo_count is unchanged.
- FIFO order: first in, first out. Read and write pointers wrap modulo FIFO_DEPTH.
- TX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - In IDLE, when echo_en = 1 and fifo_count > 0 in cycle k, pop one word in cycle k. uart_tx goes 0 at cycle k+1.
  - Each bit lasts exactly DIV clocks; data is sent LSB first, then parity, then STOP_BITS stop bits of 1.
  - After the last stop bit, the next start bit may begin on the following cycle, giving back-to-back frames of exactly (1+DATA_BITS+P+STOP_BITS)*DIV clocks.
  - Deasserting echo_en mid-frame lets the current frame complete; no further pops.
- RX and TX are fully independent; simultaneous RX completion and TX pop are legal.
- No combinational path from any input to any output.

Test Plan:
- Common setup for all scenarios: CLK_FREQ=160, BAUD=10 (DIV=16), DATA_BITS=8, PARITY=0, STOP_BITS=1, FIFO_DEPTH=16, unless overridden below.
- 8N1 loopback: drive 0x55 on uart_rx, echo_en=1 -> rx_valid pulse with rx_data=0x55 and no errors; uart_tx then sends a start bit, bits 1,0,1,0,1,0,1,0, and a stop bit, each exactly 16 clocks.
- PARITY=2: send 0xA3 with parity bit 1 -> parity_err=1 with rx_valid, rx_data=0xA3, fifo_count stays 0, no TX activity. Resend with parity bit 0 -> echoed with parity bit 0.
- Break: send 0x00 with stop bit 0 -> frame_err=1, no push. A subsequent good 0x3C (after line returns high) is received normally.
- Buffering: echo_en=0, send 18 good bytes 0x00..0x11 -> fifo_count=16, overflow pulses on 0x10 and 0x11. Then set echo_en=1 -> 0x00..0x0F echoed in order, back-to-back at 160 clocks/frame, and fifo_count reaches 0.
- Glitch and format: uart_rx low for 4 clocks -> no rx_valid. Then with DATA_BITS=7, PARITY=1, STOP_BITS=2, send 0x41 -> rx_data=0x41; echo frame is 11 bits with parity 1 and two stop bits.
- Reset mid-operation: assert reset during TX data bit 3 with fifo_count=5 -> uart_tx=1 and fifo_count=0 without waiting for a Clock edge. After release, the line stays idle high.

Source files
------------

// File: rtl/uart_fifo_echo.sv
// uart_fifo_echo: UART receiver with parity/stop checking, an RX FIFO for good
// bytes, and a transmitter that echoes the FIFO contents back out.
// Ports:
//   Clock       system clock, rising edge
//   reset       asynchronous active-high reset
//   uart_rx     serial input (idle high, asynchronous to Clock)
//   uart_tx     serial output (idle high, registered)
//   echo_en     1 = drain the FIFO onto uart_tx
//   rx_data     last received data word (held until the next frame)
//   rx_valid    1-cycle pulse per completed RX frame
//   parity_err  pulse with rx_valid on parity mismatch
//   frame_err   pulse with rx_valid when any stop bit sampled 0
//   overflow    pulse when a good byte is dropped because the FIFO is full
//   fifo_count  current FIFO occupancy
module uart_fifo_echo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        Clock,
    input  logic                        reset,
    input  logic                        uart_rx,
    output logic                        uart_tx,
    input  logic                        echo_en,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] BIT_END   = CW'(DIV - 1);
    localparam logic [CW-1:0] MID       = CW'(DIV / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [AW:0]   CNT_EMPTY = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_STEP  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_t;

    // Parity bit that accompanies d on the line for the configured mode.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) begin
            parity_bit = ~(^d);
        end else begin
            parity_bit = ^d;
        end
    endfunction

    logic                 rx_meta_r, rx_sync_r, rx_prev_r;
    uart_state_t          rx_state_r, rx_state_s, tx_state_r, tx_state_s;
    logic [CW-1:0]        rx_cnt_r, rx_cnt_s, tx_cnt_r, tx_cnt_s;
    logic [3:0]           rx_bit_r, rx_bit_s, tx_bit_r, tx_bit_s;
    logic [DATA_BITS-1:0] rx_shift_r, rx_shift_s, tx_shift_r, tx_shift_s;
    logic                 rx_perr_r, rx_perr_s, rx_ferr_r, rx_ferr_s, rx_done_s;
    logic                 tx_par_r, tx_par_s, tx_line_r, tx_line_s;
    logic                 pop_s, push_s, drop_s, good_s, start_ok_s;
    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [AW:0]          count_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r, parity_err_r, frame_err_r, overflow_r;

    assign uart_tx    = tx_line_r;
    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overflow   = overflow_r;
    assign fifo_count = count_r;

    // Two-flop synchroniser plus a delayed copy for start-edge detection.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX next state: start is checked at mid-bit, later bits sampled every DIV clocks.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r;
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        rx_perr_s  = rx_perr_r;
        rx_ferr_s  = rx_ferr_r;
        rx_done_s  = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                rx_cnt_s = CNT_ZERO;
                if (rx_prev_r && !rx_sync_r) begin
                    rx_state_s = ST_START;
                    rx_perr_s  = 1'b0;
                    rx_ferr_s  = 1'b0;
                end else begin
                    rx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_r == MID) begin
                    rx_cnt_s = CNT_ZERO;
                    rx_bit_s = 4'd0;
                    // A high line at mid-start is a glitch, not a frame.
                    if (rx_sync_r) begin
                        rx_state_s = ST_IDLE;
                    end else begin
                        rx_state_s = ST_DATA;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_r == BIT_END) begin
                    rx_cnt_s   = CNT_ZERO;
                    rx_shift_s = {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
                    if (rx_bit_r == DATA_LAST) begin
                        rx_bit_s = 4'd0;
                        if (PARITY != 0) begin
                            rx_state_s = ST_PARITY;
                        end else begin
                            rx_state_s = ST_STOP;
                        end
                    end else begin
                        rx_bit_s = rx_bit_r + 4'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (rx_cnt_r == BIT_END) begin
                    rx_cnt_s   = CNT_ZERO;
                    rx_perr_s  = (rx_sync_r != parity_bit(rx_shift_r));
                    rx_state_s = ST_STOP;
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (rx_cnt_r == BIT_END) begin
                    rx_cnt_s  = CNT_ZERO;
                    rx_ferr_s = rx_ferr_r | ~rx_sync_r;
                    // Leave mid stop bit so the next start edge is never missed.
                    if (rx_bit_r == STOP_LAST) begin
                        rx_done_s  = 1'b1;
                        rx_state_s = ST_IDLE;
                    end else begin
                        rx_bit_s = rx_bit_r + 4'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_state_s = ST_IDLE;
            end
        endcase
    end

    // RX state registers.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= 4'd0;
            rx_shift_r <= '0;
            rx_perr_r  <= 1'b0;
            rx_ferr_r  <= 1'b0;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
            rx_perr_r  <= rx_perr_s;
            rx_ferr_r  <= rx_ferr_s;
        end
    end

    // FIFO push decision; a same-cycle pop frees a slot even when full.
    always_comb begin
        good_s = rx_done_s && !rx_perr_s && !rx_ferr_s;
        push_s = good_s && ((count_r != CNT_FULL) || pop_s);
        drop_s = good_s && !push_s;
    end

    // TX next state; the final stop cycle may pop directly for back-to-back frames.
    always_comb begin
        start_ok_s = echo_en && (count_r != CNT_EMPTY);
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_par_s   = tx_par_r;
        tx_line_s  = tx_line_r;
        pop_s      = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                tx_line_s = 1'b1;
                tx_cnt_s  = CNT_ZERO;
                if (start_ok_s) begin
                    pop_s      = 1'b1;
                    tx_shift_s = mem_r[rd_ptr_r];
                    tx_par_s   = parity_bit(mem_r[rd_ptr_r]);
                    tx_state_s = ST_START;
                    tx_line_s  = 1'b0;
                end else begin
                    tx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_cnt_r == BIT_END) begin
                    tx_cnt_s   = CNT_ZERO;
                    tx_bit_s   = 4'd0;
                    tx_state_s = ST_DATA;
                    tx_line_s  = tx_shift_r[0];
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt_r == BIT_END) begin
                    tx_cnt_s = CNT_ZERO;
                    if (tx_bit_r == DATA_LAST) begin
                        tx_bit_s = 4'd0;
                        if (PARITY != 0) begin
                            tx_state_s = ST_PARITY;
                            tx_line_s  = tx_par_r;
                        end else begin
                            tx_state_s = ST_STOP;
                            tx_line_s  = 1'b1;
                        end
                    end else begin
                        tx_bit_s   = tx_bit_r + 4'd1;
                        tx_shift_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
                        tx_line_s  = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (tx_cnt_r == BIT_END) begin
                    tx_cnt_s   = CNT_ZERO;
                    tx_bit_s   = 4'd0;
                    tx_state_s = ST_STOP;
                    tx_line_s  = 1'b1;
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_cnt_r == BIT_END) begin
                    tx_cnt_s = CNT_ZERO;
                    if (tx_bit_r != STOP_LAST) begin
                        tx_bit_s = tx_bit_r + 4'd1;
                    end else if (start_ok_s) begin
                        pop_s      = 1'b1;
                        tx_shift_s = mem_r[rd_ptr_r];
                        tx_par_s   = parity_bit(mem_r[rd_ptr_r]);
                        tx_state_s = ST_START;
                        tx_line_s  = 1'b0;
                    end else begin
                        tx_state_s = ST_IDLE;
                        tx_line_s  = 1'b1;
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_state_s = ST_IDLE;
                tx_line_s  = 1'b1;
            end
        endcase
    end

    // TX state registers; the line idles high.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 4'd0;
            tx_shift_r <= '0;
            tx_par_r   <= 1'b0;
            tx_line_r  <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_par_r   <= tx_par_s;
            tx_line_r  <= tx_line_s;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge Clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= rx_shift_r;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_EMPTY;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_STEP;
                2'b01:   count_r <= count_r - CNT_STEP;
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered RX status outputs, one cycle after the final stop sample.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            rx_valid_r   <= rx_done_s;
            parity_err_r <= rx_done_s & rx_perr_s;
            frame_err_r  <= rx_done_s & rx_ferr_s;
            overflow_r   <= drop_s;
            if (rx_done_s) begin
                rx_data_r <= rx_shift_r;
            end else begin
                rx_data_r <= rx_data_r;
            end
        end
    end
endmodule

// File: tb/tb_uart_fifo_echo.sv
`timescale 1ns/1ps
module tb_uart_fifo_echo;
    typedef struct { logic [7:0] d; logic p; logic f; logic o; } rx_rec_t;
    typedef struct { logic [15:0] bits; logic clean; int t; } tx_rec_t;
    typedef struct { logic [7:0] d; bit badpar; bit stop0; logic ep; logic ef; int ecnt; } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic rx0, rx2, rx7, tx0, tx2, tx7, en0, en2, en7;
    logic v0, v2, v7, p0, p2, p7, f0, f2, f7, o0, o2, o7;
    logic [7:0] data0, data2;
    logic [6:0] data7;
    logic [4:0] cnt0, cnt2, cnt7;

    rx_rec_t rxq0[$], rxq2[$], rxq7[$];
    tx_rec_t txq0[$], txq2[$], txq7[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_fifo_echo #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_d0 (
        .Clock(clk), .reset(rst), .uart_rx(rx0), .uart_tx(tx0), .echo_en(en0), .rx_data(data0),
        .rx_valid(v0), .parity_err(p0), .frame_err(f0), .overflow(o0), .fifo_count(cnt0));
    uart_fifo_echo #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_d2 (
        .Clock(clk), .reset(rst), .uart_rx(rx2), .uart_tx(tx2), .echo_en(en2), .rx_data(data2),
        .rx_valid(v2), .parity_err(p2), .frame_err(f2), .overflow(o2), .fifo_count(cnt2));
    uart_fifo_echo #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u_d7 (
        .Clock(clk), .reset(rst), .uart_rx(rx7), .uart_tx(tx7), .echo_en(en7), .rx_data(data7),
        .rx_valid(v7), .parity_err(p7), .frame_err(f7), .overflow(o7), .fifo_count(cnt7));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop bits; unused bits idle 1.
    function automatic logic [15:0] mkframe(input logic [7:0] d, input int nd, input int par,
                                            input bit badpar, input int ns, input bit stop0);
        logic [15:0] f;
        int pos;
        int ones;
        bit pb;
        f = 16'hFFFF;
        f[0] = 1'b0;
        pos = 1;
        ones = 0;
        for (int i = 0; i < nd; i++) begin
            f[pos] = d[i];
            ones += int'(d[i]);
            pos++;
        end
        if (par != 0) begin
            pb = (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            if (badpar) pb = !pb;
            f[pos] = pb;
            pos++;
        end
        for (int i = 0; i < ns; i++) begin
            f[pos] = !stop0;
            pos++;
        end
        return f;
    endfunction

    function automatic int nbits(input int w);
        return (w == 0) ? 10 : 11;
    endfunction

    function automatic logic [15:0] frm(input int w, input logic [7:0] d, input bit badpar, input bit stop0);
        if (w == 0) return mkframe(d, 8, 0, badpar, 1, stop0);
        else if (w == 1) return mkframe(d, 8, 2, badpar, 1, stop0);
        else return mkframe(d, 7, 1, badpar, 2, stop0);
    endfunction

    function automatic logic get_tx(input int w);
        return (w == 0) ? tx0 : ((w == 1) ? tx2 : tx7);
    endfunction

    function automatic int rxsize(input int w);
        return (w == 0) ? rxq0.size() : ((w == 1) ? rxq2.size() : rxq7.size());
    endfunction

    function automatic rx_rec_t rxat(input int w, input int i);
        return (w == 0) ? rxq0[i] : ((w == 1) ? rxq2[i] : rxq7[i]);
    endfunction

    function automatic int txsize(input int w);
        return (w == 0) ? txq0.size() : ((w == 1) ? txq2.size() : txq7.size());
    endfunction

    function automatic tx_rec_t txat(input int w, input int i);
        return (w == 0) ? txq0[i] : ((w == 1) ? txq2[i] : txq7[i]);
    endfunction

    task automatic set_rx(input int w, input logic v);
        if (w == 0) rx0 = v;
        else if (w == 1) rx2 = v;
        else rx7 = v;
    endtask

    // Drives a frame, 16 clocks per bit; must be called just after a falling edge.
    task automatic send(input int w, input logic [15:0] f);
        for (int i = 0; i < nbits(w); i++) begin
            set_rx(w, f[i]);
            repeat (16) @(negedge clk);
        end
        set_rx(w, 1'b1);
    endtask

    task automatic wait_tx(input int w, input int n, input int budget, input string name);
        int k;
        k = 0;
        while (txsize(w) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(txsize(w) >= n), 32'd1);
    endtask

    // Decodes uart_tx frames by sampling every clock; clean means each bit was constant for 16 clocks.
    task automatic tx_mon(input int w);
        tx_rec_t r;
        logic s, first;
        forever begin
            @(negedge clk);
            if (get_tx(w) === 1'b0) begin
                r.bits = 16'hFFFF;
                r.clean = 1'b1;
                r.t = cyc;
                first = 1'b0;
                for (int b = 0; b < nbits(w); b++) begin
                    for (int c = 0; c < 16; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        s = get_tx(w);
                        if (c == 0) first = s;
                        if (s !== first) r.clean = 1'b0;
                        if (c == 8) r.bits[b] = s;
                    end
                end
                if (w == 0) txq0.push_back(r);
                else if (w == 1) txq2.push_back(r);
                else txq7.push_back(r);
            end
        end
    endtask

    initial tx_mon(0);
    initial tx_mon(1);
    initial tx_mon(2);

    // Records every completed RX frame with its status flags.
    always @(negedge clk) begin
        if (v0 === 1'b1) rxq0.push_back('{data0, p0, f0, o0});
        if (v2 === 1'b1) rxq2.push_back('{data2, p2, f2, o2});
        if (v7 === 1'b1) rxq7.push_back('{{1'b0, data7}, p7, f7, o7});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        rx_rec_t r;
        tx_rec_t tr;
        logic [7:0] exp_q[$];
        logic [7:0] d;
        bit bp, s0;
        int b, t, z;

        tbl[0] = '{8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[1] = '{8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 2};
        tbl[5] = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 3};

        rst = 1'b1; rx0 = 1'b1; rx2 = 1'b1; rx7 = 1'b1;
        en0 = 1'b0; en2 = 1'b0; en7 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx0", 32'(tx0), 32'd1);
        check("reset_cnt0", 32'(cnt0), 32'd0);
        check("reset_valid0", 32'(v0), 32'd0);
        check("reset_data0", 32'(data0), 32'd0);
        check("reset_flags0", 32'({p0, f0, o0}), 32'd0);
        check("reset_tx7", 32'(tx7), 32'd1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 loopback of 0x55
        en0 = 1'b1;
        b = rxsize(0); t = txsize(0);
        send(0, frm(0, 8'h55, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        check("lb_valid", 32'(rxsize(0)), 32'(b + 1));
        r = rxat(0, b);
        check("lb_data", 32'(r.d), 32'h55);
        check("lb_errs", 32'({r.p, r.f}), 32'd0);
        wait_tx(0, t + 1, 400, "lb_tx_timeout");
        tr = txat(0, t);
        check("lb_frame", 32'(tr.bits), 32'(frm(0, 8'h55, 1'b0, 1'b0)));
        check("lb_bit_width", 32'(tr.clean), 32'd1);

        // break (stop bit 0) then good 0x3C
        b = rxsize(0); t = txsize(0);
        send(0, frm(0, 8'h00, 1'b0, 1'b1));
        repeat (2) @(negedge clk);
        check("brk_valid", 32'(rxsize(0)), 32'(b + 1));
        r = rxat(0, b);
        check("brk_ferr", 32'(r.f), 32'd1);
        check("brk_perr", 32'(r.p), 32'd0);
        repeat (200) @(negedge clk);
        check("brk_no_tx", 32'(txsize(0)), 32'(t));
        check("brk_cnt", 32'(cnt0), 32'd0);
        send(0, frm(0, 8'h3C, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        r = rxat(0, b + 1);
        check("brk_good_data", 32'(r.d), 32'h3C);
        check("brk_good_errs", 32'({r.p, r.f}), 32'd0);
        wait_tx(0, t + 1, 400, "brk_tx_timeout");
        check("brk_good_frame", 32'(txat(0, t).bits), 32'(frm(0, 8'h3C, 1'b0, 1'b0)));

        // buffering with overflow, then back-to-back drain
        en0 = 1'b0;
        b = rxsize(0); t = txsize(0);
        for (int i = 0; i < 18; i++) begin
            send(0, frm(0, 8'(i), 1'b0, 1'b0));
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("buf_cnt_full", 32'(cnt0), 32'd16);
        check("buf_rx_count", 32'(rxsize(0)), 32'(b + 18));
        for (int i = 0; i < 18; i++) begin
            r = rxat(0, b + i);
            check($sformatf("buf_ovf_%0d", i), 32'(r.o), 32'(i >= 16));
        end
        check("buf_no_tx", 32'(txsize(0)), 32'(t));
        en0 = 1'b1;
        wait_tx(0, t + 16, 16 * 160 + 400, "buf_tx_timeout");
        for (int i = 0; i < 16; i++) begin
            tr = txat(0, t + i);
            check($sformatf("buf_frame_%0d", i), 32'(tr.bits), 32'(frm(0, 8'(i), 1'b0, 1'b0)));
            if (i > 0) check($sformatf("buf_spacing_%0d", i), 32'(tr.t - txat(0, t + i - 1).t), 32'd160);
        end
        repeat (200) @(negedge clk);
        check("buf_drained", 32'(cnt0), 32'd0);
        check("buf_tx_total", 32'(txsize(0)), 32'(t + 16));

        // even parity: bad parity suppressed, good parity echoed
        en2 = 1'b1;
        b = rxsize(1); t = txsize(1);
        send(1, frm(1, 8'hA3, 1'b1, 1'b0));
        repeat (2) @(negedge clk);
        check("par_valid", 32'(rxsize(1)), 32'(b + 1));
        r = rxat(1, b);
        check("par_perr", 32'(r.p), 32'd1);
        check("par_data", 32'(r.d), 32'hA3);
        check("par_cnt", 32'(cnt2), 32'd0);
        repeat (200) @(negedge clk);
        check("par_no_tx", 32'(txsize(1)), 32'(t));
        send(1, frm(1, 8'hA3, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        check("par_good_perr", 32'(rxat(1, b + 1).p), 32'd0);
        wait_tx(1, t + 1, 400, "par_tx_timeout");
        tr = txat(1, t);
        check("par_echo_frame", 32'(tr.bits), 32'(frm(1, 8'hA3, 1'b0, 1'b0)));
        check("par_echo_pbit", 32'(tr.bits[9]), 32'd0);

        // table-driven vectors with echo held off
        en2 = 1'b0;
        t = txsize(1);
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            b = rxsize(1);
            send(1, frm(1, tbl[i].d, tbl[i].badpar, tbl[i].stop0));
            repeat (4) @(negedge clk);
            check($sformatf("tbl%0d_valid", i), 32'(rxsize(1)), 32'(b + 1));
            r = rxat(1, b);
            check($sformatf("tbl%0d_data", i), 32'(r.d), 32'(tbl[i].d));
            check($sformatf("tbl%0d_perr", i), 32'(r.p), 32'(tbl[i].ep));
            check($sformatf("tbl%0d_ferr", i), 32'(r.f), 32'(tbl[i].ef));
            check($sformatf("tbl%0d_cnt", i), 32'(cnt2), 32'(tbl[i].ecnt));
            if (!tbl[i].ep && !tbl[i].ef) exp_q.push_back(tbl[i].d);
        end
        en2 = 1'b1;
        wait_tx(1, t + exp_q.size(), 2000, "tbl_tx_timeout");
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("tbl_echo_%0d", i), 32'(txat(1, t + i).bits), 32'(frm(1, exp_q[i], 1'b0, 1'b0)));

        // randomized frames against a queue model of the echo stream
        repeat (200) @(negedge clk);
        t = txsize(1);
        exp_q.delete();
        for (int k = 0; k < 24; k++) begin
            d = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 4) == 0);
            s0 = ($urandom_range(0, 7) == 0);
            b = rxsize(1);
            send(1, frm(1, d, bp, s0));
            repeat (1) @(negedge clk);
            check($sformatf("rnd%0d_valid", k), 32'(rxsize(1)), 32'(b + 1));
            r = rxat(1, b);
            check($sformatf("rnd%0d_rx", k), 32'({r.d, r.p, r.f}), 32'({d, bp, s0}));
            if (!bp && !s0) exp_q.push_back(d);
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        wait_tx(1, t + exp_q.size(), 2000, "rnd_tx_timeout");
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rnd_echo_%0d", i), 32'(txat(1, t + i).bits), 32'(frm(1, exp_q[i], 1'b0, 1'b0)));
        check("rnd_cnt_end", 32'(cnt2), 32'd0);

        // glitch then 7O2 format
        b = rxsize(2);
        rx7 = 1'b0;
        repeat (4) @(negedge clk);
        rx7 = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_valid", 32'(rxsize(2)), 32'(b));
        en7 = 1'b1;
        t = txsize(2);
        send(2, frm(2, 8'h41, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        check("fmt_valid", 32'(rxsize(2)), 32'(b + 1));
        r = rxat(2, b);
        check("fmt_data", 32'(r.d), 32'h41);
        check("fmt_errs", 32'({r.p, r.f}), 32'd0);
        wait_tx(2, t + 1, 400, "fmt_tx_timeout");
        tr = txat(2, t);
        check("fmt_frame", 32'(tr.bits), 32'(frm(2, 8'h41, 1'b0, 1'b0)));
        check("fmt_pbit", 32'(tr.bits[8]), 32'd1);
        check("fmt_stops", 32'(tr.bits[10:9]), 32'd3);
        check("fmt_clean", 32'(tr.clean), 32'd1);

        // asynchronous reset during TX data bit 3
        en0 = 1'b0;
        for (int i = 0; i < 6; i++) send(0, frm(0, 8'h00, 1'b0, 1'b0));
        repeat (4) @(negedge clk);
        check("rst_cnt6", 32'(cnt0), 32'd6);
        en0 = 1'b1;
        z = 0;
        while (tx0 !== 1'b0 && z < 50) begin
            @(negedge clk);
            z++;
        end
        check("rst_start_seen", 32'(z < 50), 32'd1);
        repeat (72) @(negedge clk);
        check("rst_cnt5", 32'(cnt0), 32'd5);
        check("rst_bit3_low", 32'(tx0), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_tx", 32'(tx0), 32'd1);
        check("rst_async_cnt", 32'(cnt0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        z = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1) z++;
        end
        check("rst_idle_after", 32'(z), 32'd0);
        check("rst_cnt_after", 32'(cnt0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
